inst_prefetch_unit: RTL
=======================

// Module: inst_prefetch_unit
// PURPOSE
//  Instruction fetch front end feeding instWord/pcOut to the single-cycle core's decoder.
//  Issues sequential word fetches to instruction memory over a valid/ready request channel and accepts in-order responses.
//  Buffers fetched words in a DEPTH-entry queue; a redirect (branch/jump) flushes the queue and discards stale in-flight responses.
// PARAMETERS
//  DBITS            32       data/address width
//  START_PC         32'h40   fetch address after reset
//  INST_SIZE        32'd4    PC increment per instruction
//  DEPTH            4        instruction queue entries (power of 2, >=2)
//  MAX_OUTSTANDING  4        max requests issued but not yet answered (<=15)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  reset        in   1      asynchronous, active-low reset
//  redirect     in   1      flush and restart fetch at redirectPc
//  redirectPc   in   DBITS  new fetch address; bits [1:0] forced to 0
//  memReqValid  out  1      fetch request valid
//  memReqAddr   out  DBITS  fetch address (word aligned)
//  memReqReady  in   1      memory accepts request this cycle
//  memRspValid  in   1      response word valid (in order, >=1 cycle after accept)
//  memRspData   in   DBITS  fetched instruction word
//  instValid    out  1      queue head valid
//  instWord     out  DBITS  queue head instruction
//  instPc       out  DBITS  address of queue head instruction
//  instReady    in   1      consumer takes head this cycle
//  stallCycles  out  32     only with INST_PREFETCH_PERF_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=0, async): fetchPc=START_PC, rspPc=START_PC, queue empty, outstanding=0, discard=0;
//   memReqValid=0, memReqAddr=START_PC, instValid=0, instWord=0, instPc=0.
//  Request: memReqValid = !redirect && (count+outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING);
//   memReqAddr = fetchPc. On valid&&ready: fetchPc += INST_SIZE (wraps mod 2^DBITS), outstanding++.
//   memReqValid/addr from registers only, no combinational path from memReqReady.
//  Response: if discard>0, word dropped, discard--. Else push {rspPc, memRspData}, rspPc += INST_SIZE, outstanding--.
//   Space is guaranteed by the issue rule; a push is never refused.
//  Output: instValid = (count!=0); instWord/instPc = head entry, driven from storage. Pop on instValid&&instReady.
//   Push and pop in the same cycle are both performed; count unchanged. Push into empty queue visible next cycle (1-cycle min latency rsp->instValid).
//  Redirect (takes priority over everything in that cycle):
//   queue flushed (count=0, pointers reset), pop ignored, no request issued;
//   fetchPc <= rspPc <= {redirectPc[DBITS-1:2],2'b00};
//   discard <= discard + outstanding - (memRspValid ? 1 : 0); outstanding <= 0; a response arriving that cycle is dropped.
//   Back-to-back redirects: last one wins; discard accumulates correctly.
//  Counters: count, outstanding, discard sized to hold DEPTH / MAX_OUTSTANDING / 2*MAX_OUTSTANDING without wrap.
//  Protocol error: memRspValid with outstanding+discard==0 -> response ignored, simulation assertion fires.
// CONFIGURATION
//  INST_PREFETCH_PERF_EN defined: stallCycles port present; 32-bit counter, reset 0, +1 each cycle instReady=1 && instValid=0
//   (not counted in redirect cycle); saturates at 32'hFFFFFFFF.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset release, memReqReady=1, 1-cycle memory returning addr^32'hA5A5A5A5, instReady=1 -> instPc 0x40,0x44,0x48... each with matching instWord, one per cycle after fill.
//  2 instReady=0, memory always ready -> exactly DEPTH=4 requests (0x40..0x4C), memReqValid then stays 0; instValid=1, head 0x40 held stable.
//  3 3-cycle memory latency, 3 requests outstanding, redirect with redirectPc=0x103 -> next request addr 0x100, 3 stale responses dropped, first instPc=0x100.
//  4 Redirect in same cycle as a response and a pop -> response dropped, discard=outstanding-1, queue empty next cycle, no request that cycle.
//  5 fetchPc=0xFFFFFFFC via redirect -> requests 0xFFFFFFFC then 0x00000000; reset asserted mid-burst -> all outputs to reset values immediately, fetch restarts at 0x40.
//  6 (INST_PREFETCH_PERF_EN) memReqReady=0 for 10 cycles with instReady=1 after reset -> stallCycles=10; without macro, port absent and build clean.

Source files
------------

// File: rtl/inst_prefetch_unit.sv
// Sequential instruction prefetcher: issues word fetches, queues returned words, flushes on redirect.
// Optional stall-cycle counter and stallCycles_o port exist only when INST_PREFETCH_PERF_EN is defined.
module inst_prefetch_unit #(
    parameter int unsigned      DBITS           = 32,
    parameter logic [DBITS-1:0] START_PC        = DBITS'('h40),
    parameter logic [DBITS-1:0] INST_SIZE       = DBITS'(4),
    parameter int unsigned      DEPTH           = 4,
    parameter int unsigned      MAX_OUTSTANDING = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             redirect_i,
    input  logic [DBITS-1:0] redirectPc_i,
    output logic             memReqValid_o,
    output logic [DBITS-1:0] memReqAddr_o,
    input  logic             memReqReady_i,
    input  logic             memRspValid_i,
    input  logic [DBITS-1:0] memRspData_i,
    output logic             instValid_o,
    output logic [DBITS-1:0] instWord_o,
    output logic [DBITS-1:0] instPc_o,
    input  logic             instReady_i
`ifdef INST_PREFETCH_PERF_EN
    ,
    output logic [31:0]      stallCycles_o
`endif
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int OSW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int DSW  = $clog2(2 * MAX_OUTSTANDING + 1);
    localparam int SUMW = ((CNTW > OSW) ? CNTW : OSW) + 1;

    logic [DBITS-1:0] fetchPc_q, fetchPc_d;
    logic [DBITS-1:0] rspPc_q, rspPc_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [PTRW-1:0]  rdPtr_q, rdPtr_d;
    logic [PTRW-1:0]  wrPtr_q, wrPtr_d;
    logic [OSW-1:0]   outstanding_q, outstanding_d;
    logic [DSW-1:0]   discard_q, discard_d;
    logic [DBITS-1:0] wordMem_q [DEPTH];
    logic [DBITS-1:0] pcMem_q   [DEPTH];

    logic [DBITS-1:0] alignedPc;
    logic [SUMW-1:0]  inFlight;
    logic [DSW-1:0]   pendingTotal;
    logic             reqAllowed;
    logic             reqFire;
    logic             pushFire;
    logic             popFire;
    logic             unusedPcBits;

    assign alignedPc    = {redirectPc_i[DBITS-1:2], 2'b00};
    assign unusedPcBits = ^redirectPc_i[1:0];

    // Issue only when every word already requested is guaranteed a queue slot.
    assign inFlight      = SUMW'(count_q) + SUMW'(outstanding_q);
    assign reqAllowed    = (inFlight < SUMW'(DEPTH)) && (outstanding_q < OSW'(MAX_OUTSTANDING));
    assign memReqValid_o = reset_ni && !redirect_i && reqAllowed;
    assign memReqAddr_o  = fetchPc_q;
    assign reqFire       = memReqValid_o && memReqReady_i;

    assign instValid_o = (count_q != '0);
    assign instWord_o  = wordMem_q[rdPtr_q];
    assign instPc_o    = pcMem_q[rdPtr_q];

    always_comb begin
        fetchPc_d     = fetchPc_q;
        rspPc_d       = rspPc_q;
        count_d       = count_q;
        rdPtr_d       = rdPtr_q;
        wrPtr_d       = wrPtr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        pushFire      = 1'b0;
        popFire       = 1'b0;
        pendingTotal  = discard_q + DSW'(outstanding_q);

        if (redirect_i) begin
            // Everything still in flight becomes stale; a response landing now is one of them.
            fetchPc_d     = alignedPc;
            rspPc_d       = alignedPc;
            count_d       = '0;
            rdPtr_d       = '0;
            wrPtr_d       = '0;
            outstanding_d = '0;
            if (memRspValid_i && (pendingTotal != '0)) begin
                discard_d = pendingTotal - DSW'(1);
            end else begin
                discard_d = pendingTotal;
            end
        end else begin
            popFire = instValid_o && instReady_i;
            if (reqFire) begin
                fetchPc_d = fetchPc_q + INST_SIZE;
            end
            if (memRspValid_i) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - DSW'(1);
                end else if (outstanding_q != '0) begin
                    pushFire = 1'b1;
                end
            end
            if (pushFire) begin
                rspPc_d = rspPc_q + INST_SIZE;
                wrPtr_d = wrPtr_q + PTRW'(1);
            end
            if (popFire) begin
                rdPtr_d = rdPtr_q + PTRW'(1);
            end
            case ({reqFire, pushFire})
                2'b10:   outstanding_d = outstanding_q + OSW'(1);
                2'b01:   outstanding_d = outstanding_q - OSW'(1);
                default: outstanding_d = outstanding_q;
            endcase
            case ({pushFire, popFire})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fetchPc_q     <= START_PC;
            rspPc_q       <= START_PC;
            count_q       <= '0;
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            rspPc_q       <= rspPc_d;
            count_q       <= count_d;
            rdPtr_q       <= rdPtr_d;
            wrPtr_q       <= wrPtr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                wordMem_q[i] <= '0;
                pcMem_q[i]   <= '0;
            end
        end else if (pushFire) begin
            wordMem_q[wrPtr_q] <= memRspData_i;
            pcMem_q[wrPtr_q]   <= rspPc_q;
        end
    end

`ifdef INST_PREFETCH_PERF_EN
    logic [31:0] stallCycles_q;

    // Counts cycles the consumer wanted an instruction but none was ready; saturates.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stallCycles_q <= '0;
        end else if (!redirect_i && instReady_i && !instValid_o && (stallCycles_q != 32'hFFFF_FFFF)) begin
            stallCycles_q <= stallCycles_q + 32'd1;
        end
    end

    assign stallCycles_o = stallCycles_q;
`endif

`ifndef SYNTHESIS
    rspWithoutRequest: assert property (@(posedge clk_i) disable iff (!reset_ni)
        memRspValid_i |-> ((outstanding_q != '0) || (discard_q != '0)));
`endif

endmodule
